branch_history_table: RTL and testbench

//  Dynamic direction predictor that replaces static prediction for conditional branches.
//  Two ports:
//  - IF-stage lookup: returns a taken/not-taken prediction for the fetch PC.
//  - EX-stage update: trains the table with the resolved outcome from the branch-resolution

---
 rtl/bp_pkg.sv | 19 +
 rtl/sat_counter2.sv | 19 +
 rtl/branch_history_table.sv | 68 ++++++
 tb/tb_branch_history_table.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch direction predictor: 2-bit counter states,
// the default reset state and the PC-to-table index mapping.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_t;

    localparam logic [1:0] CNT_INIT_DEFAULT = WNT;

    // Word-aligned index: drops pc[1:0] and keeps the next idx_w bits.
    function automatic logic [31:0] idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_history_table.sv
// Untagged table of 2-bit counters: combinational lookup at IF, training at EX,
// mispredict flag for flush logic and saturating branch/miss perf counters.
module branch_history_table
    import bp_pkg::*;
#(
    parameter int         ENTRIES  = 64,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = CNT_INIT_DEFAULT,
    parameter int         STAT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_pc,
    input  logic              if_is_branch,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [31:0]       ex_pc,
    input  logic              ex_taken,
    input  logic              ex_pred_taken,
    output logic              ex_mispredict,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] miss_count
);

    logic [1:0]       table_q [ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [1:0]       ex_cnt_next;
    logic             update;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    assign if_idx = IDX_W'(idx(if_pc, IDX_W));
    assign ex_idx = IDX_W'(idx(ex_pc, IDX_W));
    assign update = ex_valid & ~ex_stall;

    // Gating by if_is_branch keeps an unknown if_pc from reaching the prediction.
    assign if_pred_taken = if_is_branch & table_q[if_idx][1];
    assign ex_mispredict = update & (ex_taken ^ ex_pred_taken);

    sat_counter2 u_sat (
        .cnt      (table_q[ex_idx]),
        .taken    (ex_taken),
        .cnt_next (ex_cnt_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_INIT;
        end else if (update) begin
            table_q[ex_idx] <= ex_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (update) begin
            br_count <= sat_inc(br_count);
            if (ex_mispredict) miss_count <= sat_inc(miss_count);
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench: fixed vector table, reset/saturation sequences and a
// randomized run against a behavioural predictor model.
module tb_branch_history_table;

    localparam int STAT_W  = 4;
    localparam int ENTRIES = 64;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       if_pc = '0;
    logic              if_is_branch = 1'b0;
    logic              if_pred_taken;
    logic              ex_valid = 1'b0;
    logic              ex_stall = 1'b0;
    logic [31:0]       ex_pc = '0;
    logic              ex_taken = 1'b0;
    logic              ex_pred_taken = 1'b0;
    logic              ex_mispredict;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] miss_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] lk_pc;
        logic        lk_br;
        logic        vld;
        logic        stl;
        logic [31:0] up_pc;
        logic        tk;
        logic        pt;
        logic        exp_pred;
        logic        exp_mis;
        int          exp_br;
        int          exp_miss;
    } vec_t;

    vec_t vecs [9];

    int model_cnt [ENTRIES];
    int model_br;
    int model_miss;

    branch_history_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (6),
        .CNT_INIT(2'b01),
        .STAT_W  (STAT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_pc        (if_pc),
        .if_is_branch (if_is_branch),
        .if_pred_taken(if_pred_taken),
        .ex_valid     (ex_valid),
        .ex_stall     (ex_stall),
        .ex_pc        (ex_pc),
        .ex_taken     (ex_taken),
        .ex_pred_taken(ex_pred_taken),
        .ex_mispredict(ex_mispredict),
        .br_count     (br_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] lk_pc, input logic lk_br,
                                input logic vld, input logic stl, input logic [31:0] up_pc,
                                input logic tk, input logic pt, input logic exp_pred,
                                input logic exp_mis, input int exp_br, input int exp_miss);
        vec_t v;
        v.lk_pc = lk_pc; v.lk_br = lk_br; v.vld = vld; v.stl = stl; v.up_pc = up_pc;
        v.tk = tk; v.pt = pt; v.exp_pred = exp_pred; v.exp_mis = exp_mis;
        v.exp_br = exp_br; v.exp_miss = exp_miss;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if_pc         = v.lk_pc;
        if_is_branch  = v.lk_br;
        ex_valid      = v.vld;
        ex_stall      = v.stl;
        ex_pc         = v.up_pc;
        ex_taken      = v.tk;
        ex_pred_taken = v.pt;
    endtask

    task automatic idleInputs();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_taken = 1'b0; ex_pred_taken = 1'b0;
        if_is_branch = 1'b0;
    endtask

    task automatic doReset();
        idleInputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < ENTRIES; i++) model_cnt[i] = 1;
        model_br = 0;
        model_miss = 0;
    endtask

    initial begin
        vecs[0] = mk(32'h14,  1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1);
        vecs[1] = mk(32'h14,  1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1);
        vecs[2] = mk(32'h114, 1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1, 1'b1, 1'b0, 3, 1);
        vecs[3] = mk(32'h18,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 3, 1);
        vecs[4] = mk(32'h14,  1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1);
        vecs[5] = mk(32'h20,  1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1, 4, 2);
        vecs[6] = mk(32'h20,  1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 5, 3);
        vecs[7] = mk(32'h20,  1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 6, 4);
        vecs[8] = mk(32'h20,  1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 6, 4);

        // Reset state: every entry weakly not-taken, counters cleared.
        doReset();
        if_is_branch = 1'b1;
        for (int a = 0; a < 256; a += 4) begin
            if_pc = 32'(a);
            #1;
            checkOutput($sformatf("reset_pred_%0h", a), int'(if_pred_taken), 0);
        end
        checkOutput("reset_br", int'(br_count), 0);
        checkOutput("reset_miss", int'(miss_count), 0);

        // Vector table: training, aliasing, same-cycle lookup, stall.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("vec%0d_pred", i), int'(if_pred_taken), int'(vecs[i].exp_pred));
            checkOutput($sformatf("vec%0d_mis", i), int'(ex_mispredict), int'(vecs[i].exp_mis));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_br", i), int'(br_count), vecs[i].exp_br);
            checkOutput($sformatf("vec%0d_miss", i), int'(miss_count), vecs[i].exp_miss);
        end

        // Perf counters saturate, then an async reset clears everything mid-cycle.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(mk(32'h14, 1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0));
            @(posedge clk);
            #1;
        end
        idleInputs();
        if_pc = 32'h14;
        if_is_branch = 1'b1;
        #1;
        checkOutput("sat_br", int'(br_count), STAT_MAX);
        checkOutput("sat_miss", int'(miss_count), STAT_MAX);
        checkOutput("sat_pred", int'(if_pred_taken), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_br", int'(br_count), 0);
        checkOutput("async_miss", int'(miss_count), 0);
        checkOutput("async_pred", int'(if_pred_taken), 0);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the behavioural model.
        doReset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] lpc, upc;
            logic lbr, vld, stl, tk, pt;
            int li, ui, exp_pred, exp_mis;
            lpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            upc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            lbr = 1'($urandom);
            vld = ($urandom_range(0, 3) != 0);
            stl = ($urandom_range(0, 4) == 0);
            tk  = 1'($urandom);
            pt  = 1'($urandom);
            li = int'((lpc >> 2) % ENTRIES);
            ui = int'((upc >> 2) % ENTRIES);
            exp_pred = (lbr && model_cnt[li] >= 2) ? 1 : 0;
            exp_mis  = (vld && !stl && tk != pt) ? 1 : 0;
            applyStimulus(mk(lpc, lbr, vld, stl, upc, tk, pt, 1'b0, 1'b0, 0, 0));
            #3;
            checkOutput($sformatf("rnd%0d_pred", n), int'(if_pred_taken), exp_pred);
            checkOutput($sformatf("rnd%0d_mis", n), int'(ex_mispredict), exp_mis);
            @(posedge clk);
            #1;
            if (vld && !stl) begin
                if (tk) model_cnt[ui] = (model_cnt[ui] < 3) ? model_cnt[ui] + 1 : 3;
                else    model_cnt[ui] = (model_cnt[ui] > 0) ? model_cnt[ui] - 1 : 0;
                if (model_br < STAT_MAX) model_br++;
                if (exp_mis == 1 && model_miss < STAT_MAX) model_miss++;
            end
            checkOutput($sformatf("rnd%0d_br", n), int'(br_count), model_br);
            checkOutput($sformatf("rnd%0d_miss", n), int'(miss_count), model_miss);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
